// File: rtl/frame_buffer_write_scheduler.sv
// Frame buffer write scheduler.
// Owns the write port of the frame_buffer back buffer. Every swap starts a
// frame: an optional hardware clear of the whole buffer, then exclusive
// write access for one selected source until that source reports done.
// Swaps that cut a clear or a grant short are counted as overruns.
module frame_buffer_write_scheduler #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int OVERRUN_WIDTH     = 8,
    // Derived from the frame size; leave at its default.
    parameter int PIXEL_ADDR_WIDTH  = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    input  logic                        swap,
    input  logic [1:0]                  sel,
    input  logic                        clear_en,
    input  logic                        clear_value,
    input  logic                        src0_wr_en,
    input  logic [PIXEL_ADDR_WIDTH-1:0] src0_wr_addr,
    input  logic                        src0_wr_data,
    input  logic                        src0_done,
    input  logic                        src1_wr_en,
    input  logic [PIXEL_ADDR_WIDTH-1:0] src1_wr_addr,
    input  logic                        src1_wr_data,
    input  logic                        src1_done,
    output logic [1:0]                  src_grant,
    output logic                        frame_start,
    output logic                        fb_wr_en,
    output logic [PIXEL_ADDR_WIDTH-1:0] fb_wr_addr,
    output logic                        fb_wr_data,
    output logic                        busy,
    output logic [OVERRUN_WIDTH-1:0]    overrun_count
);

    localparam int PIXELS = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
    localparam logic [PIXEL_ADDR_WIDTH-1:0] LAST_ADDR = PIXEL_ADDR_WIDTH'(PIXELS - 1);
    // One bit wider than an address so the frame size itself is representable.
    localparam logic [PIXEL_ADDR_WIDTH:0] PIXELS_EXT = (PIXEL_ADDR_WIDTH + 1)'(PIXELS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        GRANT = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t                        state_reg;
    state_t                        state_next;
    logic [1:0]                    sel_reg;
    logic                          clear_value_reg;
    logic [PIXEL_ADDR_WIDTH-1:0]   clear_addr_reg;
    logic [OVERRUN_WIDTH-1:0]      overrun_reg;
    logic                          frame_start_reg;
    logic                          fwd_en_reg;
    logic [PIXEL_ADDR_WIDTH-1:0]   fwd_addr_reg;
    logic                          fwd_data_reg;

    // Per-source views so the grant/select logic is written once per source.
    logic [1:0]                    grant_bits;
    logic [1:0]                    src_wr_en_vec;
    logic [1:0]                    src_wr_data_vec;
    logic [1:0]                    src_done_vec;
    logic [PIXEL_ADDR_WIDTH-1:0]   src_addr_arr  [2];
    logic [PIXEL_ADDR_WIDTH-1:0]   addr_terms    [2];

    logic                          granted_done;
    logic                          granted_wr_en;
    logic [PIXEL_ADDR_WIDTH-1:0]   granted_addr;
    logic                          granted_data;
    logic                          fwd_en_next;
    logic                          in_clear;
    logic                          in_grant;

    assign src_wr_en_vec   = {src1_wr_en, src0_wr_en};
    assign src_wr_data_vec = {src1_wr_data, src0_wr_data};
    assign src_done_vec    = {src1_done, src0_done};
    assign src_addr_arr[0] = src0_wr_addr;
    assign src_addr_arr[1] = src1_wr_addr;

    assign in_clear = (state_reg == CLEAR);
    assign in_grant = (state_reg == GRANT);

    // Source i is granted when in GRANT with latched sel == i+1 (sel 0/3 grant nobody).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign grant_bits[gi] = in_grant && (sel_reg == 2'(gi + 1));
            assign addr_terms[gi] = grant_bits[gi] ? src_addr_arr[gi] : '0;
        end
    endgenerate

    assign granted_done  = |(grant_bits & src_done_vec);
    assign granted_wr_en = |(grant_bits & src_wr_en_vec);
    assign granted_data  = |(grant_bits & src_wr_data_vec);
    assign granted_addr  = addr_terms[0] | addr_terms[1];
    // Out-of-frame addresses never reach the buffer.
    assign fwd_en_next   = granted_wr_en && ({1'b0, granted_addr} < PIXELS_EXT);

    // Next-state logic: swap restarts a frame from any state; nothing moves while ce is low.
    always_comb begin
        state_next = state_reg;
        if (ce) begin
            if (swap) begin
                state_next = clear_en ? CLEAR : GRANT;
            end else begin
                case (state_reg)
                    CLEAR:   if (clear_addr_reg == LAST_ADDR) state_next = GRANT;
                    GRANT:   if (grant_bits == 2'b00 || granted_done) state_next = WAIT;
                    default: state_next = state_reg;
                endcase
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Frame configuration latched at frame start; clear_en is captured by the state choice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg         <= 2'b00;
            clear_value_reg <= 1'b0;
        end else if (ce && swap) begin
            sel_reg         <= sel;
            clear_value_reg <= clear_value;
        end
    end

    // Clear address: restarts at 0 on every frame start, advances once per ce cycle in CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_addr_reg <= '0;
        end else if (ce) begin
            if (swap || (in_clear && clear_addr_reg == LAST_ADDR)) begin
                clear_addr_reg <= '0;
            end else if (in_clear) begin
                clear_addr_reg <= clear_addr_reg + 1'b1;
            end
        end
    end

    // Saturating count of swaps that arrive while a clear or grant is still running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_reg <= '0;
        end else if (ce && swap && (in_clear || in_grant) && (overrun_reg != '1)) begin
            overrun_reg <= overrun_reg + 1'b1;
        end
    end

    // frame_start is a one-cycle pulse after an accepted swap; it is not stretched across ce-low cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= ce && swap;
        end
    end

    // Granted-source write pipeline (one cycle). A write in the swap cycle is dropped so it cannot collide with a restarted clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_en_reg   <= 1'b0;
            fwd_addr_reg <= '0;
            fwd_data_reg <= 1'b0;
        end else if (ce) begin
            fwd_en_reg   <= fwd_en_next && !swap;
            fwd_addr_reg <= granted_addr;
            fwd_data_reg <= granted_data;
        end
    end

    assign src_grant     = ce ? grant_bits : 2'b00;
    assign frame_start   = ce && frame_start_reg;
    assign fb_wr_en      = ce && (in_clear || fwd_en_reg);
    assign fb_wr_addr    = in_clear ? clear_addr_reg  : fwd_addr_reg;
    assign fb_wr_data    = in_clear ? clear_value_reg : fwd_data_reg;
    assign busy          = in_clear || in_grant;
    assign overrun_count = overrun_reg;

endmodule

// File: tb/tb_frame_buffer_write_scheduler.sv
// Testbench for frame_buffer_write_scheduler on an 8x4 (32-pixel) frame:
// a vector table, hand-written multi-cycle sequences, and a random run
// checked against a pixel-count based reference model.
module tb_frame_buffer_write_scheduler;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int PIX = H * V;
    localparam int AW  = 5;
    localparam int OW  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          swap;
    logic [1:0]    sel;
    logic          clear_en;
    logic          clear_value;
    logic          s0_en, s0_data, s0_done;
    logic          s1_en, s1_data, s1_done;
    logic [AW-1:0] s0_addr, s1_addr;
    logic [1:0]    src_grant;
    logic          frame_start;
    logic          fb_wr_en;
    logic [AW-1:0] fb_wr_addr;
    logic          fb_wr_data;
    logic          busy;
    logic [OW-1:0] overrun_count;

    int n_cmp = 0;
    int n_bad = 0;

    frame_buffer_write_scheduler #(
        .HOR_ACTIVE_PIXELS (H),
        .VER_ACTIVE_PIXELS (V),
        .OVERRUN_WIDTH     (OW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ce            (ce),
        .swap          (swap),
        .sel           (sel),
        .clear_en      (clear_en),
        .clear_value   (clear_value),
        .src0_wr_en    (s0_en),
        .src0_wr_addr  (s0_addr),
        .src0_wr_data  (s0_data),
        .src0_done     (s0_done),
        .src1_wr_en    (s1_en),
        .src1_wr_addr  (s1_addr),
        .src1_wr_data  (s1_data),
        .src1_done     (s1_done),
        .src_grant     (src_grant),
        .frame_start   (frame_start),
        .fb_wr_en      (fb_wr_en),
        .fb_wr_addr    (fb_wr_addr),
        .fb_wr_data    (fb_wr_data),
        .busy          (busy),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        ce = 1'b1; swap = 1'b0; sel = 2'd0; clear_en = 1'b0; clear_value = 1'b0;
        s0_en = 1'b0; s0_addr = '0; s0_data = 1'b0; s0_done = 1'b0;
        s1_en = 1'b0; s1_addr = '0; s1_data = 1'b0; s1_done = 1'b0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Drives a swap for one cycle and returns to idle inputs after the edge.
    task automatic start_frame(input logic [1:0] s, input logic c_en, input logic c_val);
        swap = 1'b1; sel = s; clear_en = c_en; clear_value = c_val;
        tick();
        idle();
    endtask

    typedef struct {
        logic          ce, swap;
        logic [1:0]    sel;
        logic          clr, cval;
        logic          s0_en; logic [AW-1:0] s0_a; logic s0_d, s0_dn;
        logic          s1_en; logic [AW-1:0] s1_a; logic s1_d, s1_dn;
        logic [1:0]    e_grant;
        logic          e_fs, e_we;
        logic [AW-1:0] e_addr;
        logic          e_data, e_busy;
        logic [OW-1:0] e_ovr;
    } vec_t;

    vec_t vt [16];

    // Reference model state: frame progress expressed as pixels left to clear,
    // whether a grant phase is open, which source owns it, and the one write in flight.
    int        m_clear_left;
    bit        m_in_grant;
    int        m_src;
    bit        m_cval;
    bit        m_pv;
    bit [AW-1:0] m_pa;
    bit        m_pd;
    int        m_ovr;
    bit        m_fs;

    initial begin
        int wr_cnt, err_cnt, fs_cnt, exp_addr;
        logic [1:0] e_grant;
        logic e_we, e_data, e_busy, e_fs;
        logic [AW-1:0] e_addr;
        bit [1:0] wen, dn;
        bit [AW-1:0] wa [2];
        bit wd [2];

        //            ce swp sel clr cv  s0en a d dn  s1en a  d dn   gnt fs we adr d bsy ovr
        vt[0]  = '{1'b1,1'b1,2'd2,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0,  2'b00,1'b0,1'b0,5'd0,1'b0,1'b0,8'd0};
        vt[1]  = '{1'b1,1'b0,2'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0,  2'b10,1'b1,1'b0,5'd0,1'b0,1'b1,8'd0};
        vt[2]  = '{1'b1,1'b0,2'd0,1'b0,1'b0, 1'b1,5'd7,1'b0,1'b0, 1'b1,5'd5,1'b1,1'b0,  2'b10,1'b0,1'b0,5'd0,1'b0,1'b1,8'd0};
        vt[3]  = '{1'b1,1'b0,2'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0,  2'b10,1'b0,1'b1,5'd5,1'b1,1'b1,8'd0};
        vt[4]  = '{1'b1,1'b0,2'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b1, 1'b0,5'd0,1'b0,1'b0,  2'b10,1'b0,1'b0,5'd0,1'b0,1'b1,8'd0};
        vt[5]  = '{1'b1,1'b0,2'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b1,5'd30,1'b1,1'b1, 2'b10,1'b0,1'b0,5'd0,1'b0,1'b1,8'd0};
        vt[6]  = '{1'b1,1'b0,2'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0,  2'b00,1'b0,1'b1,5'd30,1'b1,1'b0,8'd0};
        vt[7]  = '{1'b1,1'b0,2'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0,  2'b00,1'b0,1'b0,5'd0,1'b0,1'b0,8'd0};
        vt[8]  = '{1'b1,1'b1,2'd3,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0,  2'b00,1'b0,1'b0,5'd0,1'b0,1'b0,8'd0};
        vt[9]  = '{1'b1,1'b0,2'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0,  2'b00,1'b1,1'b0,5'd0,1'b0,1'b1,8'd0};
        vt[10] = '{1'b1,1'b0,2'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0,  2'b00,1'b0,1'b0,5'd0,1'b0,1'b0,8'd0};
        vt[11] = '{1'b0,1'b1,2'd1,1'b1,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0,  2'b00,1'b0,1'b0,5'd0,1'b0,1'b0,8'd0};
        vt[12] = '{1'b1,1'b0,2'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0,  2'b00,1'b0,1'b0,5'd0,1'b0,1'b0,8'd0};
        vt[13] = '{1'b1,1'b1,2'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0,  2'b00,1'b0,1'b0,5'd0,1'b0,1'b0,8'd0};
        vt[14] = '{1'b1,1'b0,2'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0,  2'b00,1'b1,1'b0,5'd0,1'b0,1'b1,8'd0};
        vt[15] = '{1'b1,1'b0,2'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0,  2'b00,1'b0,1'b0,5'd0,1'b0,1'b0,8'd0};

        // ---------------- Reset asserted in the middle of a clear ----------------
        do_reset();
        chk("reset_busy", busy, 0);
        chk("reset_ovr", overrun_count, 0);
        start_frame(2'd1, 1'b1, 1'b1);
        repeat (5) tick();
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", fb_wr_en, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_grant", src_grant, 0);
        chk("async_rst_addr", fb_wr_addr, 0);
        chk("async_rst_data", fb_wr_data, 0);
        chk("async_rst_fs", frame_start, 0);
        tick();
        rst_n = 1'b1;
        wr_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (fb_wr_en || busy) wr_cnt++;
        end
        chk("post_reset_idle", wr_cnt, 0);

        // ---------------- Vector table: grant/forward/done/sel=3/ce-low swap ----------------
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ce = vt[i].ce; swap = vt[i].swap; sel = vt[i].sel;
            clear_en = vt[i].clr; clear_value = vt[i].cval;
            s0_en = vt[i].s0_en; s0_addr = vt[i].s0_a; s0_data = vt[i].s0_d; s0_done = vt[i].s0_dn;
            s1_en = vt[i].s1_en; s1_addr = vt[i].s1_a; s1_data = vt[i].s1_d; s1_done = vt[i].s1_dn;
            #1;
            chk($sformatf("vec%0d_grant", i), src_grant, vt[i].e_grant);
            chk($sformatf("vec%0d_fs", i), frame_start, vt[i].e_fs);
            chk($sformatf("vec%0d_we", i), fb_wr_en, vt[i].e_we);
            if (vt[i].e_we) begin
                chk($sformatf("vec%0d_addr", i), fb_wr_addr, vt[i].e_addr);
                chk($sformatf("vec%0d_data", i), fb_wr_data, vt[i].e_data);
            end
            chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
            chk($sformatf("vec%0d_ovr", i), overrun_count, vt[i].e_ovr);
            tick();
        end
        idle();

        // ---------------- Full clear then grant to src0 ----------------
        do_reset();
        start_frame(2'd1, 1'b1, 1'b1);
        wr_cnt = 0; err_cnt = 0; fs_cnt = 0;
        for (int cyc = 1; cyc <= 35; cyc++) begin
            #1;
            if (frame_start) fs_cnt++;
            if (cyc == 1) chk("clr_fs_first", frame_start, 1);
            if (fb_wr_en) begin
                wr_cnt++;
                if (fb_wr_addr !== AW'(cyc - 1) || fb_wr_data !== 1'b1 || cyc > 32) err_cnt++;
            end
            if (cyc == 32) chk("clr_grant_c32", src_grant, 2'b00);
            if (cyc == 33) chk("clr_grant_c33", src_grant, 2'b01);
            tick();
        end
        chk("clr_fs_count", fs_cnt, 1);
        chk("clr_writes", wr_cnt, 32);
        chk("clr_seq_err", err_cnt, 0);
        s0_done = 1'b1;
        tick();
        s0_done = 1'b0;
        #1;
        chk("done_grant_drop", src_grant, 0);
        chk("done_busy_drop", busy, 0);
        tick();

        // ---------------- Overrun during clear, restart, saturation ----------------
        do_reset();
        start_frame(2'd1, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        #1;
        chk("ovr_at_addr", fb_wr_addr, 10);
        swap = 1'b1; sel = 2'd1; clear_en = 1'b1; clear_value = 1'b1;
        tick();
        idle();
        chk("ovr_count1", overrun_count, 1);
        wr_cnt = 0; err_cnt = 0;
        for (int cyc = 0; cyc < 34; cyc++) begin
            if (fb_wr_en) begin
                if (fb_wr_addr !== AW'(wr_cnt) || fb_wr_data !== 1'b1) err_cnt++;
                wr_cnt++;
            end
            tick();
        end
        chk("ovr_restart_writes", wr_cnt, 32);
        chk("ovr_restart_err", err_cnt, 0);
        chk("ovr_in_grant", src_grant, 2'b01);
        for (int n = 2; n <= 301; n++) begin
            start_frame(2'd1, 1'b1, 1'b0);
            if (n == 254) chk("ovr_count254", overrun_count, 254);
            if (n == 255) chk("ovr_count255", overrun_count, 255);
        end
        chk("ovr_saturated", overrun_count, 255);

        // ---------------- ce toggling during clear ----------------
        do_reset();
        start_frame(2'd0, 1'b1, 1'b0);
        wr_cnt = 0; err_cnt = 0; exp_addr = 0;
        for (int cyc = 0; cyc < 100 && wr_cnt < 32; cyc++) begin
            ce = cyc[0];
            #1;
            if (!ce && fb_wr_en) err_cnt++;
            if (ce && fb_wr_en) begin
                if (fb_wr_addr !== AW'(exp_addr) || fb_wr_data !== 1'b0) err_cnt++;
                exp_addr++;
                wr_cnt++;
            end
            tick();
        end
        ce = 1'b1;
        chk("ce_clear_writes", wr_cnt, 32);
        chk("ce_clear_err", err_cnt, 0);

        // ---------------- Randomized run against the reference model ----------------
        do_reset();
        m_clear_left = 0; m_in_grant = 0; m_src = -1; m_cval = 0;
        m_pv = 0; m_pa = '0; m_pd = 0; m_ovr = 0; m_fs = 0;
        err_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ce = ($urandom_range(0, 9) != 0);
            swap = ($urandom_range(0, 59) == 0);
            sel = 2'($urandom_range(0, 3));
            clear_en = 1'($urandom_range(0, 1));
            clear_value = 1'($urandom_range(0, 1));
            s0_en = 1'($urandom_range(0, 1)); s0_addr = AW'($urandom); s0_data = 1'($urandom);
            s1_en = 1'($urandom_range(0, 1)); s1_addr = AW'($urandom); s1_data = 1'($urandom);
            s0_done = ($urandom_range(0, 24) == 0);
            s1_done = ($urandom_range(0, 24) == 0);
            #1;
            e_busy  = (m_clear_left > 0) || m_in_grant;
            e_grant = (ce && m_in_grant && m_src >= 0) ? (2'b01 << m_src) : 2'b00;
            e_we    = ce && ((m_clear_left > 0) || m_pv);
            e_addr  = (m_clear_left > 0) ? AW'(PIX - m_clear_left) : m_pa;
            e_data  = (m_clear_left > 0) ? m_cval : m_pd;
            e_fs    = ce && m_fs;
            chk($sformatf("rnd%0d_grant", cyc), src_grant, e_grant);
            chk($sformatf("rnd%0d_fs", cyc), frame_start, e_fs);
            chk($sformatf("rnd%0d_we", cyc), fb_wr_en, e_we);
            if (e_we) begin
                chk($sformatf("rnd%0d_addr", cyc), fb_wr_addr, e_addr);
                chk($sformatf("rnd%0d_data", cyc), fb_wr_data, e_data);
            end
            chk($sformatf("rnd%0d_busy", cyc), busy, e_busy);
            chk($sformatf("rnd%0d_ovr", cyc), overrun_count, m_ovr);
            // Model update for this clock edge.
            m_fs = ce && swap;
            if (ce) begin
                wen = {s1_en, s0_en}; dn = {s1_done, s0_done};
                wa[0] = s0_addr; wa[1] = s1_addr; wd[0] = s0_data; wd[1] = s1_data;
                if (swap) begin
                    if (m_clear_left > 0 || m_in_grant) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
                    m_src  = (sel == 2'd1 || sel == 2'd2) ? int'(sel) - 1 : -1;
                    m_cval = clear_value;
                    m_pv   = 0;
                    m_clear_left = clear_en ? PIX : 0;
                    m_in_grant   = !clear_en;
                end else begin
                    m_pv = m_in_grant && m_src >= 0 && wen[m_src] && (int'(wa[m_src]) < PIX);
                    if (m_src >= 0) begin
                        m_pa = wa[m_src];
                        m_pd = wd[m_src];
                    end
                    if (m_clear_left > 0) begin
                        m_clear_left--;
                        if (m_clear_left == 0) m_in_grant = 1;
                    end else if (m_in_grant) begin
                        if (m_src < 0 || dn[m_src]) m_in_grant = 0;
                    end
                end
            end
            tick();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
